// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider with shadowed period/high-time config.
// Optional macro CLK_DIV_GEN_PHASE_EN adds phase_cfg: per-channel start offset (phase mod P).
module clk_div_gen #(
  parameter int NCH = 3,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*CW-1:0] period_cfg,
  input  logic [NCH*CW-1:0] high_cfg,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [NCH*CW-1:0] phase_cfg,
`endif
  input  logic              cfg_load,
  input  logic              sync_start,
  output logic [NCH-1:0]    clk_out,
  output logic [NCH-1:0]    tick,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    cfg_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [1:0]    st, st_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] p_act, h_act, p_sh, h_sh;
    logic [CW-1:0] p_nx, h_nx, p_in, h_in, h_eff, start_v;
    logic          pend, pend_nx, apply, use_in, wrap, run_nx;
    logic          co_r, tk_r, err_r;

    assign p_in = period_cfg[i*CW +: CW];
    assign h_in = high_cfg[i*CW +: CW];
    assign wrap = (cnt >= p_act - CW'(1));

`ifdef CLK_DIV_GEN_PHASE_EN
    logic [CW-1:0] ph_in;
    assign ph_in   = phase_cfg[i*CW +: CW];
    assign start_v = (p_nx < CW'(2)) ? '0 : (ph_in % p_nx);
`else
    assign start_v = '0;
`endif

    // Config selection: a same-cycle cfg_load+sync_start bypasses the shadow.
    always_comb begin
      apply  = 1'b0;
      use_in = 1'b0;
      if (st == S_IDLE) begin
        apply = pend;
      end else if (sync_start) begin
        use_in = cfg_load;
        apply  = pend;
      end else if (wrap && ch_en[i]) begin
        apply = pend;
      end
      if (use_in) begin
        p_nx = p_in;
        h_nx = h_in;
      end else if (apply) begin
        p_nx = p_sh;
        h_nx = h_sh;
      end else begin
        p_nx = p_act;
        h_nx = h_act;
      end
      if (use_in)        pend_nx = 1'b0;
      else if (cfg_load) pend_nx = 1'b1;
      else if (apply)    pend_nx = 1'b0;
      else               pend_nx = pend;
    end

    always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      case (st)
        S_IDLE: begin
          cnt_nx = '0;
          if (ch_en[i] && (p_nx >= CW'(2))) begin
            st_nx  = S_RUN;
            cnt_nx = start_v;
          end
        end
        default: begin
          if (sync_start) begin
            st_nx  = ch_en[i] ? S_RUN : S_STOP;
            cnt_nx = start_v;
          end else if (wrap) begin
            // A stopping channel leaves exactly at the period boundary.
            st_nx  = ch_en[i] ? S_RUN : S_IDLE;
            cnt_nx = '0;
          end else begin
            st_nx  = ch_en[i] ? S_RUN : S_STOP;
            cnt_nx = cnt + CW'(1);
          end
          if (p_nx < CW'(2)) begin
            st_nx  = S_IDLE;
            cnt_nx = '0;
          end
        end
      endcase
    end

    assign h_eff  = (h_nx >= p_nx) ? (p_nx - CW'(1)) : h_nx;
    assign run_nx = (st_nx != S_IDLE);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        st    <= S_IDLE;
        cnt   <= '0;
        p_act <= CW'(4);
        h_act <= CW'(2);
        p_sh  <= CW'(4);
        h_sh  <= CW'(2);
        pend  <= 1'b0;
        co_r  <= 1'b0;
        tk_r  <= 1'b0;
        err_r <= 1'b0;
      end else begin
        st    <= st_nx;
        cnt   <= cnt_nx;
        p_act <= p_nx;
        h_act <= h_nx;
        if (cfg_load) begin
          p_sh <= p_in;
          h_sh <= h_in;
        end
        pend  <= pend_nx;
        co_r  <= run_nx && (cnt_nx < h_eff);
        tk_r  <= run_nx && (cnt_nx == '0);
        err_r <= (p_nx < CW'(2));
      end
    end

    assign clk_out[i] = co_r;
    assign tick[i]    = tk_r;
    assign pending[i] = pend;
    assign cfg_err[i] = err_r;
  end

endmodule
